// File: rtl/psum_drain_ctrl_if.sv
// Bundle of the drain controller's command, memory-read and output-stream signals.
// The master modport is the controller's view; the slave modport is its environment.
interface psum_drain_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  i_start;
    logic [ADDR_WIDTH-1:0] i_base_addr;
    logic [31:0]           i_num_words;
    logic                  i_relu_en;
    logic [ADDR_WIDTH-1:0] memctrl_radd;
    logic                  memctrl_rden;
    logic [DATA_WIDTH-1:0] memctrl_odat;
    logic                  memctrl_ovld;
    logic [DATA_WIDTH-1:0] o_dat;
    logic                  o_vld;
    logic                  i_rdy;
    logic                  o_busy;
    logic                  o_done;
    logic [31:0]           dbg_rd_cnt;

    modport master (
        input  i_start, i_base_addr, i_num_words, i_relu_en,
        input  memctrl_odat, memctrl_ovld, i_rdy,
        output memctrl_radd, memctrl_rden, o_dat, o_vld, o_busy, o_done, dbg_rd_cnt
    );

    modport slave (
        output i_start, i_base_addr, i_num_words, i_relu_en,
        output memctrl_odat, memctrl_ovld, i_rdy,
        input  memctrl_radd, memctrl_rden, o_dat, o_vld, o_busy, o_done, dbg_rd_cnt
    );
endinterface

// File: rtl/psum_drain_ctrl.sv
// Drains packed psum words from accumulation memory, applies optional per-lane ReLU,
// and streams them out through a credit-protected skid FIFO.
module psum_drain_ctrl #(
    parameter int BIT_WIDTH  = 8,
    parameter int NUM_KERNEL = 4,
    parameter int DATA_WIDTH = BIT_WIDTH * NUM_KERNEL,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_DELAY  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    psum_drain_ctrl_if.master bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

    if ((FIFO_DEPTH < MEM_DELAY + 1) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) ||
        (DATA_WIDTH != BIT_WIDTH * NUM_KERNEL)) begin : g_bad_params
        $error("psum_drain_ctrl: illegal FIFO_DEPTH/MEM_DELAY/DATA_WIDTH combination");
    end

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    function automatic logic [DATA_WIDTH-1:0] relu_word(input logic [DATA_WIDTH-1:0] d,
                                                        input logic                  en);
        logic [DATA_WIDTH-1:0]       r;
        logic signed [BIT_WIDTH-1:0] lane;
        r = d;
        for (int l = 0; l < NUM_KERNEL; l++) begin
            lane = d[l*BIT_WIDTH +: BIT_WIDTH];
            if (en && (lane < 0)) r[l*BIT_WIDTH +: BIT_WIDTH] = '0;
        end
        return r;
    endfunction

    state_t                r_state, w_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_num;
    logic [31:0]           r_issue_cnt;
    logic                  r_relu;
    logic [CW-1:0]         r_outst;
    logic [CW-1:0]         r_cnt;
    logic [PW-1:0]         r_wptr, r_rptr;
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];

    logic w_vld, w_pop, w_push, w_credit, w_start_acc;
    logic w_rden, w_busy, w_done;

    assign w_vld       = (r_cnt != '0);
    assign w_pop       = w_vld && bus.i_rdy;
    // Returns from reads issued before a reset find no outstanding credit and are dropped.
    assign w_push      = bus.memctrl_ovld && (r_outst != '0);
    assign w_credit    = (({1'b0, r_cnt} + {1'b0, r_outst}) < DEPTH_C);
    assign w_start_acc = bus.i_start && (r_state == S_IDLE);

    always_comb begin
        w_next = r_state;
        w_rden = 1'b0;
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.i_start) w_next = (bus.i_num_words == 32'd0) ? S_DONE : S_READ;
            end
            S_READ: begin
                w_busy = 1'b1;
                w_rden = w_credit;
                if (w_credit && (r_issue_cnt + 32'd1 == r_num)) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                w_busy = 1'b1;
                // Looking through a final pop lets o_done land the cycle after the last beat.
                if ((r_outst == '0) && ((r_cnt == '0) || ((r_cnt == CW'(1)) && w_pop)))
                    w_next = S_DONE;
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr      <= '0;
            r_num       <= '0;
            r_relu      <= 1'b0;
            r_issue_cnt <= '0;
        end else if (w_start_acc) begin
            r_addr      <= bus.i_base_addr;
            r_num       <= bus.i_num_words;
            r_relu      <= bus.i_relu_en;
            r_issue_cnt <= '0;
        end else if (w_rden) begin
            r_addr      <= r_addr + ADDR_WIDTH'(1);
            r_issue_cnt <= r_issue_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_outst <= '0;
        end else begin
            case ({w_rden, w_push})
                2'b10:   r_outst <= r_outst + CW'(1);
                2'b01:   r_outst <= r_outst - CW'(1);
                default: r_outst <= r_outst;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= relu_word(bus.memctrl_odat, r_relu);
    end

    assign bus.memctrl_radd = r_addr;
    assign bus.memctrl_rden = w_rden;
    assign bus.o_dat        = w_vld ? r_mem[r_rptr] : '0;
    assign bus.o_vld        = w_vld;
    assign bus.o_busy       = w_busy;
    assign bus.o_done       = w_done;
    assign bus.dbg_rd_cnt   = r_issue_cnt;
endmodule
